rv32v_elem_sequencer: RTL

- Sequences one decoded vector arithmetic instruction across its element range, NUM_LANES elements per beat.
- Sits between vector decode (OPI/OPM decode output: vfu select, disable_mask) and the shared execution units (ALU/MUL/RED/PRM).
- Generates per-beat element index, per-lane active/tail enables from vl, vstart and the v0 mask.
- Tracks outstanding beats in the execution unit and reports completion.

---
 rtl/rv32v_elem_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rv32v_elem_sequencer.sv
// rv32v_elem_sequencer: walks one decoded vector arithmetic instruction
// across its element range, NUM_LANES elements per beat. It builds per-lane
// write enables from vl, vstart and the v0 mask, and it limits how many
// beats can be in flight in the execution unit. It raises done once every
// issued beat has retired.
// Optional feature macro: RV32V_SEQ_SKIP_EMPTY_EN. When this macro is
// defined, non-last beats with no active lane are stepped over internally
// and never presented to the EXU.
module rv32v_elem_sequencer #(
  parameter int NUM_LANES       = 4,
  parameter int IDXW            = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [IDXW-1:0]      issue_vl,
  input  logic [IDXW-1:0]      issue_vstart,
  input  logic                 issue_vm,
  input  logic                 issue_disable_mask,
  input  logic [1:0]           issue_vfu,
  output logic [IDXW-1:0]      mask_idx,
  input  logic [NUM_LANES-1:0] mask_bits,
  output logic                 exu_valid,
  input  logic                 exu_ready,
  output logic [1:0]           exu_vfu,
  output logic [IDXW-1:0]      exu_base,
  output logic [NUM_LANES-1:0] exu_lane_en,
  output logic                 exu_last,
  input  logic                 exu_wb,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [IDXW:0] LANE_STEP = (IDXW + 1)'(NUM_LANES);
  localparam logic [IDXW:0] ALIGN_MASK = ~((IDXW + 1)'(NUM_LANES - 1));
  localparam logic [CW-1:0] OUT_FULL = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW:0]   base_q, base_d;
  logic [CW-1:0]   out_q, out_d;
  logic [IDXW-1:0] vl_q, vstart_q;
  logic            vm_q, dm_q;
  logic [1:0]      vfu_q;
  logic            load;

  logic [NUM_LANES-1:0] lane_raw;
  logic                 last_raw;
  logic                 skip_beat;
  logic                 xfer;
  logic                 wb_take;

  // Per-lane enable: the element must lie inside [vstart, vl), and then
  // either the instruction is unmasked or v0 selects it.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [IDXW:0] elem;
    assign elem = base_q + (IDXW + 1)'(g);
    assign lane_raw[g] = (elem >= {1'b0, vstart_q}) && (elem < {1'b0, vl_q})
                         && (dm_q || vm_q || mask_bits[g]);
  end

  assign last_raw = (base_q + LANE_STEP) >= {1'b0, vl_q};
  assign mask_idx = base_q[IDXW-1:0];
  assign exu_base = base_q[IDXW-1:0];
  assign exu_vfu  = vfu_q;

`ifdef RV32V_SEQ_SKIP_EMPTY_EN
  assign skip_beat = (state_q == S_RUN) && (lane_raw == '0) && !last_raw;
`else
  assign skip_beat = 1'b0;
`endif

  // Next-state, beat advance, outstanding count and all outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    load        = 1'b0;
    issue_ready = 1'b0;
    exu_valid   = 1'b0;
    exu_lane_en = '0;
    exu_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && !flush) begin
          load = 1'b1;
          if (issue_vstart >= issue_vl) begin
            state_d = S_DONE;
          end else begin
            base_d  = {1'b0, issue_vstart} & ALIGN_MASK;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy        = 1'b1;
        exu_valid   = (out_q != OUT_FULL) && !skip_beat;
        exu_lane_en = lane_raw;
        exu_last    = last_raw;
        if ((exu_valid && exu_ready) || skip_beat) begin
          base_d = base_q + LANE_STEP;
        end
        if (exu_valid && exu_ready && last_raw) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((out_q == '0) || ((out_q == CW'(1)) && exu_wb)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  assign xfer    = exu_valid && exu_ready;
  assign wb_take = exu_wb && (out_q != '0);

  // Outstanding beats: up on transfer, down on retire, cleared by flush
  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d = '0;
    end else if (xfer && !wb_take) begin
      out_d = out_q + CW'(1);
    end else if (!xfer && wb_take) begin
      out_d = out_q - CW'(1);
    end
  end

  // State, beat pointer, counter and latched instruction fields
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      out_q    <= '0;
      vl_q     <= '0;
      vstart_q <= '0;
      vm_q     <= 1'b0;
      dm_q     <= 1'b0;
      vfu_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      out_q   <= out_d;
      if (load) begin
        vl_q     <= issue_vl;
        vstart_q <= issue_vstart;
        vm_q     <= issue_vm;
        dm_q     <= issue_disable_mask;
        vfu_q    <= issue_vfu;
      end
    end
  end

endmodule
